fpu_sequencer: RTL

- Sequences one floating-point operation on the shared FPU datapath per user command.
- Sits between the operand-entry peripherals and the FPU:
  - Captures operands A/B once entry is complete.
  - Issues a single-cycle start to the FPU and waits for completion, with a timeout guard.
  - Latches the result and exception flags into `dataR`/`flags` for the display path.

---
 rtl/fpu_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: runs one floating-point operation on the shared FPU per user command.
// It captures operands, fires a one-cycle launch strobe and waits for completion under a
// timeout guard. It then latches the result and exception flags for the display path.
// Every output is a register, so there is no combinational input-to-output path.
// i_reset is asynchronous and active-low.
module fpu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] NAN_VALUE      = 32'h7FC00000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_operands_ready,
  input  logic [31:0] i_data_a,
  input  logic [31:0] i_data_b,
  input  logic [1:0]  i_opsel,
  input  logic        i_start,
  input  logic        i_clear,
  output logic        o_alu_start,
  output logic [1:0]  o_alu_op,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  input  logic        i_alu_done,
  input  logic [31:0] i_alu_result,
  input  logic [4:0]  i_alu_flags,
  output logic [31:0] o_data_r,
  output logic [4:0]  o_flags,
  output logic        o_result_valid,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam int unsigned      CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [4:0]       TIMEOUT_FLAGS = 5'b10000;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic [31:0]        r_alu_a, w_alu_a_d;
  logic [31:0]        r_alu_b, w_alu_b_d;
  logic [1:0]         r_alu_op, w_alu_op_d;
  logic               r_alu_start, w_alu_start_d;
  logic [31:0]        r_data_r, w_data_r_d;
  logic [4:0]         r_flags, w_flags_d;
  logic               r_result_valid, w_result_valid_d;
  logic               r_busy, w_busy_d;
  logic               r_timeout, w_timeout_d;
  logic               w_capture;

  assign w_capture = i_start && i_operands_ready;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic and the next values of every output register.
  always_comb begin
    w_state_d        = r_state;
    w_cnt_d          = r_cnt;
    w_alu_a_d        = r_alu_a;
    w_alu_b_d        = r_alu_b;
    w_alu_op_d       = r_alu_op;
    w_data_r_d       = r_data_r;
    w_flags_d        = r_flags;
    w_result_valid_d = r_result_valid;
    w_timeout_d      = r_timeout;

    if (i_clear) begin
      // Clear beats any coincident start. Captured operands are kept.
      w_state_d        = StIdle;
      w_data_r_d       = '0;
      w_flags_d        = '0;
      w_result_valid_d = 1'b0;
      w_timeout_d      = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (w_capture) begin
            w_alu_a_d        = i_data_a;
            w_alu_b_d        = i_data_b;
            w_alu_op_d       = i_opsel;
            w_flags_d        = '0;
            w_result_valid_d = 1'b0;
            w_timeout_d      = 1'b0;
            w_state_d        = StIssue;
          end
        end
        StIssue: begin
          w_cnt_d   = '0;
          w_state_d = StWait;
        end
        StWait: begin
          if (r_cnt != CNT_MAX) begin
            w_cnt_d = r_cnt + CNT_ONE;
          end
          // A done on the terminal-count cycle takes priority over the timeout.
          if (i_alu_done) begin
            w_data_r_d       = i_alu_result;
            w_flags_d        = i_alu_flags;
            w_result_valid_d = 1'b1;
            w_state_d        = StDone;
          end else if (r_cnt == CNT_LAST) begin
            w_data_r_d       = NAN_VALUE;
            w_flags_d        = TIMEOUT_FLAGS;
            w_timeout_d      = 1'b1;
            w_result_valid_d = 1'b1;
            w_state_d        = StDone;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end

    // The launch strobe and busy are registered from the next state, so they line up with it.
    w_alu_start_d = (w_state_d == StIssue);
    w_busy_d      = (w_state_d == StIssue) || (w_state_d == StWait);
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt          <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_op       <= '0;
      r_alu_start    <= 1'b0;
      r_data_r       <= '0;
      r_flags        <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_d;
      r_alu_a        <= w_alu_a_d;
      r_alu_b        <= w_alu_b_d;
      r_alu_op       <= w_alu_op_d;
      r_alu_start    <= w_alu_start_d;
      r_data_r       <= w_data_r_d;
      r_flags        <= w_flags_d;
      r_result_valid <= w_result_valid_d;
      r_busy         <= w_busy_d;
      r_timeout      <= w_timeout_d;
    end
  end

  assign o_alu_start    = r_alu_start;
  assign o_alu_op       = r_alu_op;
  assign o_alu_a        = r_alu_a;
  assign o_alu_b        = r_alu_b;
  assign o_data_r       = r_data_r;
  assign o_flags        = r_flags;
  assign o_result_valid = r_result_valid;
  assign o_busy         = r_busy;
  assign o_timeout      = r_timeout;

endmodule
